// File: rtl/nt_pkg.sv
// rtl/nt_pkg.sv - shared channel indices and request bundle for the update scheduler
package nt_pkg;

   localparam int NT_N_CH = 4;

   localparam int NT_CH_DOPAMINE       = 0;
   localparam int NT_CH_SEROTONIN      = 1;
   localparam int NT_CH_NOREPINEPHRINE = 2;
   localparam int NT_CH_CORTISOL       = 3;

   typedef struct packed {
      logic inc;
      logic dec;
      logic fast;
      logic setval;
   } nt_req_t;

endpackage

// File: rtl/nt_update_scheduler_if.sv
// rtl/nt_update_scheduler_if.sv - request/pulse bundle between regulators and the scheduler
interface nt_update_scheduler_if #(
   parameter int N_CH = 4
);
   localparam int SW = $clog2(N_CH);

   logic [N_CH-1:0] req_inc;
   logic [N_CH-1:0] req_dec;
   logic [N_CH-1:0] req_fast;
   logic [N_CH-1:0] req_setval;
   logic [N_CH-1:0] inc;
   logic [N_CH-1:0] dec;
   logic [N_CH-1:0] fast;
   logic [N_CH-1:0] setval;
   logic [SW-1:0]   slot;

   modport master (
      output req_inc, req_dec, req_fast, req_setval,
      input  inc, dec, fast, setval, slot
   );

   modport slave (
      input  req_inc, req_dec, req_fast, req_setval,
      output inc, dec, fast, setval, slot
   );

endinterface

// File: rtl/nt_sched_channel.sv
// rtl/nt_sched_channel.sv - sticky pending flags, idle decay and resolution for one channel
module nt_sched_channel
   import nt_pkg::*;
#(
   parameter int DECAY_SLOTS = 8
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    serve,
   input  nt_req_t req,
   output nt_req_t pulse
);
   localparam int IW = (DECAY_SLOTS > 0) ? $clog2(DECAY_SLOTS + 1) : 1;
   localparam logic [IW-1:0] IDLE_LAST = (DECAY_SLOTS > 0) ? IW'(DECAY_SLOTS - 1) : '0;

   nt_req_t       pend;
   nt_req_t       eff;
   nt_req_t       pulse_n;
   logic [IW-1:0] idle;
   logic [IW-1:0] idle_n;

   // Requests arriving in the serve cycle itself are folded in here.
   assign eff = pend | req;

   always_comb begin
      pulse_n = '0;
      idle_n  = idle;
      if (eff.setval) begin
         pulse_n.setval = 1'b1;
         idle_n         = '0;
      end else if (eff.inc && eff.dec) begin
         idle_n = '0;
      end else if (eff.inc) begin
         pulse_n.inc  = 1'b1;
         pulse_n.fast = eff.fast;
         idle_n       = '0;
      end else if (eff.dec) begin
         pulse_n.dec  = 1'b1;
         pulse_n.fast = eff.fast;
         idle_n       = '0;
      end else if ((DECAY_SLOTS > 0) && (idle == IDLE_LAST)) begin
         pulse_n.dec = 1'b1;
         idle_n      = '0;
      end else begin
         idle_n = idle + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend  <= '0;
         idle  <= '0;
         pulse <= '0;
      end else begin
         pulse <= serve ? pulse_n : '0;
         if (serve) begin
            pend <= '0;
            idle <= idle_n;
         end else begin
            pend <= eff;
         end
      end
   end

endmodule

// File: rtl/nt_update_scheduler.sv
// rtl/nt_update_scheduler.sv - prescaled round-robin release of neurotransmitter level updates
module nt_update_scheduler
   import nt_pkg::*;
#(
   parameter int N_CH        = NT_N_CH,
   parameter int TICK_DIV    = 16,
   parameter int DECAY_SLOTS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   nt_update_scheduler_if.slave  bus
);
   localparam int CW = $clog2(TICK_DIV);
   localparam int SW = $clog2(N_CH);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SLOT_MAX = SW'(N_CH - 1);

   logic [CW-1:0]   cnt;
   logic [SW-1:0]   slot_q;
   logic            tick;
   nt_req_t         pulse [N_CH];
   logic [N_CH-1:0] inc_v, dec_v, fast_v, setval_v;

   assign tick = en && (cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         slot_q <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
         if (tick) begin
            slot_q <= (slot_q == SLOT_MAX) ? '0 : slot_q + SW'(1);
         end
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      nt_req_t req_g;
      logic    serve_g;

      assign req_g   = {bus.req_inc[gi], bus.req_dec[gi], bus.req_fast[gi], bus.req_setval[gi]};
      assign serve_g = tick && (slot_q == SW'(gi));

      nt_sched_channel #(
         .DECAY_SLOTS (DECAY_SLOTS)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .serve (serve_g),
         .req   (req_g),
         .pulse (pulse[gi])
      );
   end

   always_comb begin
      inc_v    = '0;
      dec_v    = '0;
      fast_v   = '0;
      setval_v = '0;
      for (int i = 0; i < N_CH; i++) begin
         inc_v[i]    = pulse[i].inc;
         dec_v[i]    = pulse[i].dec;
         fast_v[i]   = pulse[i].fast;
         setval_v[i] = pulse[i].setval;
      end
   end

   assign bus.inc    = inc_v;
   assign bus.dec    = dec_v;
   assign bus.fast   = fast_v;
   assign bus.setval = setval_v;
   assign bus.slot   = slot_q;

endmodule
